// File: rtl/clk_enable_gen.sv
// clk_enable_gen -- multi-channel programmable clock-enable generator.
//
// Each channel divides masterClk by a runtime-loadable divisor and produces a
// registered one-cycle enable pulse (tick) plus a 50% duty square wave (level)
// that toggles on every tick.
//
// Ports:
//   masterClk  in   single clock, all state changes on its rising edge
//   rst        in   asynchronous active-high reset
//   run        in   1 = counters advance, 0 = freeze (tick forced low)
//   sync       in   (only with CLK_ENABLE_GEN_SYNC_EN) phase-align all channels
//   div_load   in   one-cycle strobe writing div_value into channel div_sel
//   div_sel    in   channel index for div_load (out-of-range loads ignored)
//   div_value  in   new divisor (0 is stored as 1)
//   tick       out  per-channel one-cycle enable pulse
//   level      out  per-channel square wave, period 2*divisor
//
// Optional feature macro: CLK_ENABLE_GEN_SYNC_EN adds the sync input.

// Single divider channel.
module clk_enable_gen_ch #(
  parameter int               CNT_W = 27,
  parameter logic [CNT_W-1:0] INIT  = CNT_W'(1)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             run_i,
  input  logic             load_i,
  input  logic [CNT_W-1:0] load_val_i,
  input  logic             sync_i,
  output logic             tick_o,
  output logic             level_o
);
  // A zero divisor is never held; it behaves as divide-by-1.
  localparam logic [CNT_W-1:0] RST_DIV = (INIT == '0) ? CNT_W'(1) : INIT;

  logic [CNT_W-1:0] div_q, div_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             tick_q, tick_d;
  logic             level_q, level_d;

  always_comb begin
    div_d   = div_q;
    cnt_d   = cnt_q;
    tick_d  = 1'b0;
    level_d = level_q;
    if (load_i) begin
      // Load beats terminal count: restart the period, no tick, level holds.
      div_d = load_val_i;
      cnt_d = '0;
    end else if (run_i) begin
      if (cnt_q == div_q - CNT_W'(1)) begin
        cnt_d   = '0;
        tick_d  = 1'b1;
        level_d = ~level_q;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
    // Sync realigns phase on top of whatever the load decided for the divisor.
    if (sync_i) begin
      cnt_d   = '0;
      tick_d  = 1'b0;
      level_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      div_q   <= RST_DIV;
      cnt_q   <= '0;
      tick_q  <= 1'b0;
      level_q <= 1'b0;
    end else begin
      div_q   <= div_d;
      cnt_q   <= cnt_d;
      tick_q  <= tick_d;
      level_q <= level_d;
    end
  end

  assign tick_o  = tick_q;
  assign level_o = level_q;
endmodule

module clk_enable_gen #(
  parameter int                      NUM_CH   = 4,
  parameter int                      CNT_W    = 27,
  parameter logic [NUM_CH*CNT_W-1:0] DIV_INIT = {27'd33_333_333, 27'd250_000,
                                                 27'd50_000_000, 27'd100_000_000}
) (
  input  logic              masterClk,
  input  logic              rst,
  input  logic              run,
`ifdef CLK_ENABLE_GEN_SYNC_EN
  input  logic              sync,
`endif
  input  logic              div_load,
  input  logic [3:0]        div_sel,
  input  logic [CNT_W-1:0]  div_value,
  output logic [NUM_CH-1:0] tick,
  output logic [NUM_CH-1:0] level
);
  logic             sync_w;
  logic [CNT_W-1:0] load_val;

`ifdef CLK_ENABLE_GEN_SYNC_EN
  assign sync_w = sync;
`else
  assign sync_w = 1'b0;
`endif

  assign load_val = (div_value == '0) ? CNT_W'(1) : div_value;

  // Only channels 0..NUM_CH-1 exist, so a div_sel beyond them matches nothing
  // and the load is dropped.
  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    clk_enable_gen_ch #(
      .CNT_W (CNT_W),
      .INIT  (DIV_INIT[i*CNT_W +: CNT_W])
    ) u_ch (
      .clk_i      (masterClk),
      .rst_i      (rst),
      .run_i      (run),
      .load_i     (div_load && (div_sel == 4'(i))),
      .load_val_i (load_val),
      .sync_i     (sync_w),
      .tick_o     (tick[i]),
      .level_o    (level[i])
    );
  end
endmodule
